pe_array_acc: RTL and testbench

PE_ARRAY_ACC -- requirements
Module: pe_array_acc

---
 rtl/pe_array_pkg.sv | 41 ++++
 rtl/pe_acc_cell.sv | 52 +++++
 rtl/pe_array_acc.sv | 135 +++++++++++++
 tb/tb_pe_array_acc.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_array_pkg.sv
// Shared types and the saturating adder for the PE-array accumulator.
// Saturation is done on a 64-bit working width and clamped to the caller's accumulator width.
package pe_array_pkg;

    typedef enum logic [1:0] {
        MODE_MAC  = 2'b00,
        MODE_EADD = 2'b01,
        MODE_EMUL = 2'b10,
        MODE_RSVD = 2'b11
    } pe_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ACCUM = 2'b01,
        ST_HOLD  = 2'b10
    } pe_state_e;

    localparam int SAT_W = 64;

    // Exact x+y clamped to the signed acc_width range; acc_width must be at most 63.
    function automatic logic signed [SAT_W-1:0] sat_add(
        input logic signed [SAT_W-1:0] x,
        input logic signed [SAT_W-1:0] y,
        input int                      acc_width
    );
        logic signed [SAT_W:0] sum;
        logic signed [SAT_W:0] max_v;
        logic signed [SAT_W:0] min_v;
        sum   = {x[SAT_W-1], x} + {y[SAT_W-1], y};
        max_v = (SAT_W+1)'(1) <<< (acc_width - 1);
        max_v = max_v - (SAT_W+1)'(1);
        min_v = -max_v - (SAT_W+1)'(1);
        if (sum > max_v) begin
            return max_v[SAT_W-1:0];
        end else if (sum < min_v) begin
            return min_v[SAT_W-1:0];
        end
        return sum[SAT_W-1:0];
    endfunction

endpackage

// File: rtl/pe_acc_cell.sv
// One processing element: fixed-point multiply, mode select, saturating update of its accumulator.
module pe_acc_cell
    import pe_array_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 32,
    parameter int FRAC_BITS  = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr,
    input  logic                         en,
    input  logic [1:0]                   mode,
    input  logic signed [DATA_WIDTH-1:0] a,
    input  logic signed [DATA_WIDTH-1:0] b,
    output logic signed [ACC_WIDTH-1:0]  acc
);

    logic signed [2*DATA_WIDTH-1:0] prod_full;
    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0]    acc_d;
    logic signed [ACC_WIDTH-1:0]    acc_q;

    assign prod_full = a * b;
    assign prod      = prod_full >>> FRAC_BITS;

    // Job start clears; EMUL overwrites but still clamps a product wider than the accumulator.
    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            case (pe_mode_e'(mode))
                MODE_MAC:  acc_d = ACC_WIDTH'(sat_add(SAT_W'(acc_q), SAT_W'(prod), ACC_WIDTH));
                MODE_EADD: acc_d = ACC_WIDTH'(sat_add(SAT_W'(acc_q), SAT_W'(a) + SAT_W'(b), ACC_WIDTH));
                MODE_EMUL: acc_d = ACC_WIDTH'(sat_add(SAT_W'(prod), '0, ACC_WIDTH));
                default:   acc_d = acc_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/pe_array_acc.sv
// ROWS x COLS elementwise accumulator array with a shared job FSM and beat counter.
module pe_array_acc
    import pe_array_pkg::*;
#(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 32,
    parameter int FRAC_BITS  = 8,
    parameter int K_MAX      = 256,
    localparam int KW        = $clog2(K_MAX + 1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cfg_valid,
    output logic                         cfg_ready,
    input  logic [1:0]                   cfg_mode,
    input  logic [KW-1:0]                cfg_k_len,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] a_in [ROWS][COLS],
    input  logic signed [DATA_WIDTH-1:0] b_in [ROWS][COLS],
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [ACC_WIDTH-1:0]  result_out [ROWS][COLS],
    output logic                         busy,
    output logic                         err_cfg
);

    pe_state_e     state_q, state_d;
    logic [KW-1:0] cnt_q, cnt_d;
    logic [1:0]    mode_q, mode_d;
    logic          cfg_ready_q, cfg_ready_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic          busy_q, busy_d;
    logic          err_cfg_q, err_cfg_d;

    logic cfg_ok;
    logic cfg_fire;
    logic start;
    logic beat;

    assign cfg_ok   = (cfg_k_len != '0) && (32'(cfg_k_len) <= K_MAX) && (cfg_mode != MODE_RSVD);
    assign cfg_fire = cfg_valid && cfg_ready_q;
    assign start    = cfg_fire && cfg_ok;
    assign beat     = in_valid && in_ready_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        err_cfg_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cfg_fire) begin
                    if (cfg_ok) begin
                        state_d = ST_ACCUM;
                        cnt_d   = cfg_k_len;
                        mode_d  = cfg_mode;
                    end else begin
                        err_cfg_d = 1'b1;
                    end
                end
            end
            ST_ACCUM: begin
                if (beat) begin
                    cnt_d = cnt_q - KW'(1);
                    if (cnt_q == KW'(1)) begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Handshake flags are registered copies of the next state so they line up with it.
        cfg_ready_d = (state_d == ST_IDLE);
        in_ready_d  = (state_d == ST_ACCUM);
        out_valid_d = (state_d == ST_HOLD);
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            mode_q      <= MODE_MAC;
            cfg_ready_q <= 1'b1;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            err_cfg_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            cfg_ready_q <= cfg_ready_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            err_cfg_q   <= err_cfg_d;
        end
    end

    assign cfg_ready = cfg_ready_q;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign err_cfg   = err_cfg_q;

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            pe_acc_cell #(
                .DATA_WIDTH(DATA_WIDTH),
                .ACC_WIDTH (ACC_WIDTH),
                .FRAC_BITS (FRAC_BITS)
            ) u_cell (
                .clk  (clk),
                .rst_n(rst_n),
                .clr  (start),
                .en   (beat),
                .mode (mode_q),
                .a    (a_in[r][c]),
                .b    (b_in[r][c]),
                .acc  (result_out[r][c])
            );
        end
    end

endmodule

// File: tb/tb_pe_array_acc.sv
// Bench for pe_array_acc: a 32-bit and a 24-bit accumulator instance share all inputs and are
// checked against an arithmetic reference model of the elementwise job rules.
module tb_pe_array_acc;

    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int DW    = 16;
    localparam int FRAC  = 8;
    localparam int K_MAX = 256;
    localparam int KW    = $clog2(K_MAX + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, cfg_valid, in_valid, out_ready;
    logic [1:0]    cfg_mode;
    logic [KW-1:0] cfg_k_len;
    logic signed [DW-1:0] a_in [ROWS][COLS];
    logic signed [DW-1:0] b_in [ROWS][COLS];

    logic cfg_ready, in_ready, out_valid, busy, err_cfg;
    logic signed [31:0] res32 [ROWS][COLS];
    logic cfg_ready24, in_ready24, out_valid24, busy24, err_cfg24;
    logic signed [23:0] res24 [ROWS][COLS];

    pe_array_acc #(.ROWS(ROWS), .COLS(COLS), .DATA_WIDTH(DW), .ACC_WIDTH(32),
                   .FRAC_BITS(FRAC), .K_MAX(K_MAX)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_mode(cfg_mode), .cfg_k_len(cfg_k_len), .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in), .out_valid(out_valid), .out_ready(out_ready),
        .result_out(res32), .busy(busy), .err_cfg(err_cfg));

    pe_array_acc #(.ROWS(ROWS), .COLS(COLS), .DATA_WIDTH(DW), .ACC_WIDTH(24),
                   .FRAC_BITS(FRAC), .K_MAX(K_MAX)) dut24 (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready24),
        .cfg_mode(cfg_mode), .cfg_k_len(cfg_k_len), .in_valid(in_valid), .in_ready(in_ready24),
        .a_in(a_in), .b_in(b_in), .out_valid(out_valid24), .out_ready(out_ready),
        .result_out(res24), .busy(busy24), .err_cfg(err_cfg24));

    int n_cmp  = 0;
    int n_fail = 0;
    longint exp32 [ROWS][COLS];
    longint exp24 [ROWS][COLS];

    task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic longint clamp(input longint v, input int w);
        longint hi, lo;
        hi = (longint'(1) <<< (w - 1)) - 1;
        lo = -hi - 1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    // Reference rule for one accepted beat of one element.
    function automatic longint next_acc(input longint acc, input int mode, input longint a,
                                        input longint b, input int w);
        longint prod;
        prod = (a * b) >>> FRAC;
        case (mode)
            0:       return clamp(acc + prod, w);
            1:       return clamp(acc + a + b, w);
            default: return clamp(prod, w);
        endcase
    endfunction

    task automatic fill(input bit rnd, input logic [15:0] av, input logic [15:0] bv);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                a_in[r][c] = rnd ? 16'($urandom) : av;
                b_in[r][c] = rnd ? 16'($urandom) : bv;
            end
    endtask

    task automatic model_beat(input int mode);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                exp32[r][c] = next_acc(exp32[r][c], mode, longint'(a_in[r][c]), longint'(b_in[r][c]), 32);
                exp24[r][c] = next_acc(exp24[r][c], mode, longint'(a_in[r][c]), longint'(b_in[r][c]), 24);
            end
    endtask

    task automatic check_results(input string tag);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                chk({tag, "_r32"}, res32[r][c], exp32[r][c]);
                chk({tag, "_r24"}, res24[r][c], exp24[r][c]);
            end
    endtask

    task automatic start_job(input int mode, input int klen);
        int t = 0;
        while (!cfg_ready && t < 20) begin
            step();
            t++;
        end
        chk("cfg_ready_wait", cfg_ready, 1);
        cfg_valid = 1'b1;
        cfg_mode  = 2'(mode);
        cfg_k_len = KW'(klen);
        step();
        cfg_valid = 1'b0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                exp32[r][c] = 0;
                exp24[r][c] = 0;
            end
        chk("start_busy", busy, 1);
        chk("start_in_ready", in_ready, 1);
        chk("start_cfg_ready", cfg_ready, 0);
        chk("start_clear", res32[1][2], 0);
    endtask

    task automatic feed(input int mode, input int klen, input bit toggle, input bit rnd,
                        input logic [15:0] av, input logic [15:0] bv);
        int beats = 0;
        int cyc   = 0;
        bit phase = 1'b1;
        while (beats < klen && cyc < 4 * klen + 8) begin
            chk("ov_early", out_valid, 0);
            in_valid = toggle ? phase : 1'b1;
            phase    = ~phase;
            if (in_valid) fill(rnd, av, bv);
            else fill(1'b1, 16'h0, 16'h0);
            if (in_valid && in_ready) begin
                model_beat(mode);
                beats++;
            end
            step();
            cyc++;
        end
        in_valid = 1'b0;
        fill(1'b1, 16'h0, 16'h0);
        chk("beat_count", beats, klen);
        chk("ov_latency", out_valid, 1);
        chk("ov24_latency", out_valid24, 1);
        chk("hold_in_ready", in_ready, 0);
    endtask

    task automatic drain(input int hold_cycles);
        check_results("hold");
        out_ready = 1'b0;
        for (int i = 0; i < hold_cycles; i++) begin
            step();
            chk("stall_ov", out_valid, 1);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_cfg_ready", cfg_ready, 0);
            check_results("stall");
        end
        chk("hs_cfg_ready", cfg_ready, 0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("post_ov", out_valid, 0);
        chk("post_busy", busy, 0);
        chk("post_cfg_ready", cfg_ready, 1);
    endtask

    task automatic bad_job(input int mode, input int klen);
        cfg_valid = 1'b1;
        cfg_mode  = 2'(mode);
        cfg_k_len = KW'(klen);
        step();
        cfg_valid = 1'b0;
        chk("err_pulse", err_cfg, 1);
        chk("err_busy", busy, 0);
        chk("err_cfg_ready", cfg_ready, 1);
        chk("err_in_ready", in_ready, 0);
        step();
        chk("err_clear", err_cfg, 0);
        chk("err_ov", out_valid, 0);
        chk("err_busy2", busy, 0);
    endtask

    initial begin
        rst_n = 1'b0; cfg_valid = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        cfg_mode = 2'b00; cfg_k_len = '0;
        fill(1'b1, 16'h0, 16'h0);
        step();
        step();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                exp32[r][c] = 0;
                exp24[r][c] = 0;
            end
        chk("rst_ov", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err_cfg, 0);
        check_results("rst");
        rst_n = 1'b1;
        step();
        chk("rel_cfg_ready", cfg_ready, 1);

        // MAC, 3 beats of 1.0 * 2.0 in Q8
        start_job(0, 3);
        feed(0, 3, 1'b0, 1'b0, 16'h0100, 16'h0200);
        chk("mac_1536", res32[2][1], 1536);
        drain(0);

        // two beats of (-1.0 * -1.0 in Q15 terms) overflow the 24-bit instance
        start_job(0, 2);
        feed(0, 2, 1'b0, 1'b0, 16'h8000, 16'h8000);
        chk("sat24_pos", res24[3][3], 64'sd8388607);
        chk("nosat32", res32[3][3], 64'sd8388608);
        drain(0);

        // bubbles every other cycle, then a 5-cycle output stall
        start_job(0, 4);
        feed(0, 4, 1'b1, 1'b1, 16'h0, 16'h0);
        drain(5);

        bad_job(3, 2);
        bad_job(0, 0);
        bad_job(1, 300);

        for (int j = 0; j < 12; j++) begin
            int m, k;
            m = int'($urandom_range(0, 2));
            k = int'($urandom_range(1, 6));
            start_job(m, k);
            feed(m, k, 1'($urandom_range(0, 1)), 1'b1, 16'h0, 16'h0);
            drain(int'($urandom_range(0, 2)));
        end

        // reset after 2 of 4 beats aborts the job
        start_job(0, 4);
        in_valid = 1'b1;
        fill(1'b1, 16'h0, 16'h0);
        step();
        step();
        in_valid = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("abort_ov", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_acc", res32[0][0], 0);
        step();
        chk("abort_ov2", out_valid, 0);
        start_job(2, 1);
        feed(2, 1, 1'b0, 1'b0, 16'h0200, 16'h0300);
        chk("emul_600", res32[1][1], 64'sh600);
        drain(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
